fb_write_arbiter: RTL and testbench
===================================

Name: fb_write_arbiter

Overview:
- Owns the single write port of the dual-port frame-buffer RAM that the VGA output side reads.
- Arbitrates between three requesters:
  - the M4 pixel capture stream;
  - an internal memory-clear sweep, triggered on 64/80-column mode changes;
  - a low-priority overlay/status writer.
- Sequences NORMAL / MEMCLEAR / TRANSITION and presents one registered write per dotclk to the RAM.

Parameters:
- ADDR_W, 18, width of frame-buffer write address.
- FB_DEPTH, 192000, number of valid addresses (0..FB_DEPTH-1); the clear sweep covers exactly this range.
- SETTLE_CYCLES, 4, dotclk cycles spent in TRANSITION after a sweep before NORMAL resumes (range 1..15).

Ports:
- dotclk, input, 1, sole clock.
- reset, input, 1, synchronous, active-high.
- pix_valid, input, 1, pixel write request; no backpressure, at most one per cycle.
- pix_addr, input, ADDR_W, pixel address.
- pix_data, input, 1, pixel value.
- ovl_valid, input, 1, overlay write request (valid/ready).
- ovl_ready, output, 1, overlay write accepted this cycle.
- ovl_addr, input, ADDR_W, overlay address.
- ovl_data, input, 1, overlay pixel value.
- clear_start, input, 1, single-cycle pulse requesting a full clear.
- wren, output, 1, RAM write enable.
- waddr, output, ADDR_W, RAM write address.
- wdata, output, 1, RAM write data.
- busy, output, 1, high in MEMCLEAR or TRANSITION.
- drop_count, output, 16, saturating count of discarded pixel requests.

Behaviour:
- Interface: one clock, dotclk. Reset is synchronous and active-high; all state is updated only on posedge dotclk.
- Reset values:
  - state = NORMAL.
  - wren = 0, waddr = 0, wdata = 0.
  - busy = 0, drop_count = 0.
  - clear counter = 0, settle counter = 0.
- ovl_ready is combinational and is 0 while reset is asserted.
- Outputs wren, waddr and wdata are registered. A request granted in cycle N appears on the RAM port in cycle N+1, so latency is 1.
- NORMAL state:
  - Priority is pixel > overlay.
  - If pix_valid and pix_addr < FB_DEPTH: grant the pixel. Next cycle wren = 1, waddr = pix_addr, wdata = pix_data.
  - If pix_valid and pix_addr >= FB_DEPTH: drop the request, drop_count +1, no write.
  - ovl_ready = ovl_valid and not pix_valid. Any valid pixel, in-range or not, blocks the overlay.
  - When ovl_valid and ovl_ready, the overlay write is issued. An out-of-range overlay address is accepted (ready = 1) but no write is issued (wren = 0).
  - If nothing is granted, wren = 0 next cycle; waddr and wdata hold their last values.
- clear_start in NORMAL:
  - Enter MEMCLEAR with the clear counter at 0.
  - A pixel or overlay request in the same cycle is not granted. The pixel is dropped and counted; ovl_ready = 0.
- MEMCLEAR state:
  - Each cycle: wren = 1, waddr = counter, wdata = 0. The counter increments by 1 and is compared against FB_DEPTH-1 at full ADDR_W width.
  - Exactly FB_DEPTH writes are issued, addresses 0..FB_DEPTH-1 in order, with no gaps.
  - After the write to FB_DEPTH-1, go to TRANSITION.
  - Every pix_valid is dropped and counted. ovl_ready = 0.
- clear_start during MEMCLEAR or TRANSITION: restart the sweep. The counter returns to 0 and the state becomes MEMCLEAR next cycle; the address sequence restarts at 0.
- TRANSITION state:
  - wren = 0; pixels are dropped and counted; ovl_ready = 0.
  - Stay SETTLE_CYCLES cycles, then go to NORMAL.
  - The first grant can occur in the cycle the state becomes NORMAL.
- busy = 1 exactly while the state is MEMCLEAR or TRANSITION (registered with the state).
- drop_count saturates at 16'hFFFF and is cleared only by reset.
- Reset asserted mid-sweep: next cycle wren = 0, state = NORMAL, and the sweep is abandoned (not resumed).

Optional Feature:
- Macro: FB_CLEAR_VALUE_EN.
- When defined:
  - Adds input port clear_value (1 bit).
  - clear_value is sampled on the cycle clear_start is accepted (including restarts) and held for that whole sweep.
  - Every MEMCLEAR write uses the held value as wdata.
- When not defined: the port is absent and MEMCLEAR writes wdata = 0.

Test Plan:
- Pixel path: reset, then pix_valid with pix_addr = 16, 17, 18 and data 1, 0, 1 on consecutive cycles -> wren = 1 for 3 cycles starting 1 cycle later, waddr = 16, 17, 18, wdata = 1, 0, 1; drop_count = 0.
- Overlay arbitration:
  - ovl_valid held with ovl_addr = 800, pix_valid pulsing high on alternate cycles -> ovl_ready = 1 only on pix_valid = 0 cycles; one overlay write to 800 per ready cycle.
  - ovl_valid with ovl_addr = 192000 and pix_valid = 0 -> ovl_ready = 1, no write issued.
- Full clear (FB_DEPTH = 192000, SETTLE_CYCLES = 4):
  - Stimulus: pulse clear_start with pix_valid continuously high.
  - Required: exactly 192000 consecutive writes, addresses 0..191999, wdata = 0.
  - Then 4 cycles with wren = 0, busy dropping low after them, and drop_count = 192005 saturated to 65535.
- Restart: clear_start again at sweep address 1000 -> next write address 0; the total sweep completes at address 191999 once.
- Out of range: pix_addr = 192000 with pix_valid in NORMAL -> no write, drop_count increments by 1.
- Reset mid-sweep at address 5000 -> wren = 0 next cycle, busy = 0, drop_count = 0, and a following pixel to address 7 is written with 1-cycle latency.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port arbiter: pixel capture > overlay, plus a full-memory clear sweep.
// Optional FB_CLEAR_VALUE_EN adds a clear_value input used as the sweep fill value.
module fb_write_arbiter #(
   parameter int ADDR_W        = 18,
   parameter int FB_DEPTH      = 192000,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic              dotclk,
   input  logic              reset,
   input  logic              pix_valid,
   input  logic [ADDR_W-1:0] pix_addr,
   input  logic              pix_data,
   input  logic              ovl_valid,
   output logic              ovl_ready,
   input  logic [ADDR_W-1:0] ovl_addr,
   input  logic              ovl_data,
   input  logic              clear_start,
`ifdef FB_CLEAR_VALUE_EN
   input  logic              clear_value,
`endif
   output logic              wren,
   output logic [ADDR_W-1:0] waddr,
   output logic              wdata,
   output logic              busy,
   output logic [15:0]       drop_count
);

   // state      | meaning
   // NORMAL     | pixel/overlay arbitration, one write per cycle
   // MEMCLEAR   | sweeping addresses 0..FB_DEPTH-1 with the fill value
   // TRANSITION | SETTLE_CYCLES idle cycles before arbitration resumes
   typedef enum logic [1:0] {
      ST_NORMAL     = 2'd0,
      ST_MEMCLEAR   = 2'd1,
      ST_TRANSITION = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(FB_DEPTH - 1);
   localparam logic [3:0]        SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [3:0]        settle_q, settle_d;
   logic              wren_q, wren_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic              wdata_q, wdata_d;
   logic [15:0]       drop_q, drop_d;
   logic              ovl_ready_c;
   logic              pix_drop;
   logic              clr_fill;
   logic              pix_in_range;
   logic              ovl_in_range;
   logic              sweep_last;

   assign pix_in_range = (pix_addr <= LAST_ADDR);
   assign ovl_in_range = (ovl_addr <= LAST_ADDR);
   assign sweep_last   = (clr_cnt_q == LAST_ADDR);

`ifdef FB_CLEAR_VALUE_EN
   logic clr_val_q, clr_val_d;

   // Fill value is latched on every accepted clear_start, restarts included.
   always_comb begin
      clr_val_d = clr_val_q;
      if (clear_start) clr_val_d = clear_value;
   end

   always_ff @(posedge dotclk) begin
      if (reset) clr_val_q <= 1'b0;
      else       clr_val_q <= clr_val_d;
   end

   assign clr_fill = clr_val_q;
`else
   assign clr_fill = 1'b0;
`endif

   always_ff @(posedge dotclk) begin
      if (reset) state_q <= ST_NORMAL;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_NORMAL: begin
            if (clear_start) state_d = ST_MEMCLEAR;
         end
         ST_MEMCLEAR: begin
            if (clear_start)     state_d = ST_MEMCLEAR;
            else if (sweep_last) state_d = ST_TRANSITION;
         end
         ST_TRANSITION: begin
            if (clear_start)          state_d = ST_MEMCLEAR;
            else if (settle_q == 4'd0) state_d = ST_NORMAL;
         end
         default: state_d = ST_NORMAL;
      endcase
   end

   always_comb begin
      ovl_ready_c = 1'b0;
      pix_drop    = 1'b0;
      wren_d      = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      clr_cnt_d   = clr_cnt_q;
      settle_d    = settle_q;
      case (state_q)
         ST_NORMAL: begin
            if (clear_start) begin
               clr_cnt_d = '0;
               pix_drop  = pix_valid;
            end else if (pix_valid) begin
               if (pix_in_range) begin
                  wren_d  = 1'b1;
                  waddr_d = pix_addr;
                  wdata_d = pix_data;
               end else begin
                  pix_drop = 1'b1;
               end
            end else if (ovl_valid) begin
               // Out-of-range overlay writes are consumed without touching the RAM.
               ovl_ready_c = 1'b1;
               if (ovl_in_range) begin
                  wren_d  = 1'b1;
                  waddr_d = ovl_addr;
                  wdata_d = ovl_data;
               end
            end
         end
         ST_MEMCLEAR: begin
            wren_d   = 1'b1;
            waddr_d  = clr_cnt_q;
            wdata_d  = clr_fill;
            pix_drop = pix_valid;
            if (clear_start) begin
               clr_cnt_d = '0;
            end else if (sweep_last) begin
               clr_cnt_d = '0;
               settle_d  = SETTLE_LOAD;
            end else begin
               clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
         end
         ST_TRANSITION: begin
            pix_drop = pix_valid;
            if (clear_start)            clr_cnt_d = '0;
            else if (settle_q != 4'd0)  settle_d  = settle_q - 4'd1;
         end
         default: ;
      endcase
   end

   assign drop_d = (pix_drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;

   always_ff @(posedge dotclk) begin
      if (reset) begin
         clr_cnt_q <= '0;
         settle_q  <= '0;
         wren_q    <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= 1'b0;
         drop_q    <= '0;
      end else begin
         clr_cnt_q <= clr_cnt_d;
         settle_q  <= settle_d;
         wren_q    <= wren_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         drop_q    <= drop_d;
      end
   end

   assign ovl_ready  = ovl_ready_c & ~reset;
   assign wren       = wren_q;
   assign waddr      = waddr_q;
   assign wdata      = wdata_q;
   assign busy       = (state_q != ST_NORMAL);
   assign drop_count = drop_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter; a reduced FB_DEPTH keeps full sweeps short
// while two sweeps with pixels held high still drive drop_count into saturation.
module tb_fb_write_arbiter;

   localparam int ADDR_W        = 18;
   localparam int FB_DEPTH      = 32800;
   localparam int SETTLE_CYCLES = 4;

   logic              dotclk;
   logic              reset;
   logic              pix_valid;
   logic [ADDR_W-1:0] pix_addr;
   logic              pix_data;
   logic              ovl_valid;
   logic              ovl_ready;
   logic [ADDR_W-1:0] ovl_addr;
   logic              ovl_data;
   logic              clear_start;
   logic              wren;
   logic [ADDR_W-1:0] waddr;
   logic              wdata;
   logic              busy;
   logic [15:0]       drop_count;

   int errors = 0;
   int checks = 0;
   int exp_drop;

   fb_write_arbiter #(
      .ADDR_W       (ADDR_W),
      .FB_DEPTH     (FB_DEPTH),
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) dut (
      .dotclk     (dotclk),
      .reset      (reset),
      .pix_valid  (pix_valid),
      .pix_addr   (pix_addr),
      .pix_data   (pix_data),
      .ovl_valid  (ovl_valid),
      .ovl_ready  (ovl_ready),
      .ovl_addr   (ovl_addr),
      .ovl_data   (ovl_data),
      .clear_start(clear_start),
      .wren       (wren),
      .waddr      (waddr),
      .wdata      (wdata),
      .busy       (busy),
      .drop_count (drop_count)
   );

   initial dotclk = 1'b0;
   always #5 dotclk = ~dotclk;

   task automatic tick();
      @(posedge dotclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int sat16(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   initial begin
      reset = 1'b1; pix_valid = 1'b0; pix_addr = '0; pix_data = 1'b0;
      ovl_valid = 1'b0; ovl_addr = '0; ovl_data = 1'b0; clear_start = 1'b0;
      tick(); tick(); tick();
      chk("rst_wren", 32'(wren), 0);
      chk("rst_waddr", 32'(waddr), 0);
      chk("rst_wdata", 32'(wdata), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_drop", 32'(drop_count), 0);
      ovl_valid = 1'b1;
      #1 chk("rst_ovl_ready", 32'(ovl_ready), 0);
      ovl_valid = 1'b0;
      reset = 1'b0;
      tick();

      // pixel path, latency 1
      pix_valid = 1'b1; pix_addr = 16; pix_data = 1'b1;
      tick();
      chk("pix0_wren", 32'(wren), 1); chk("pix0_addr", 32'(waddr), 16); chk("pix0_data", 32'(wdata), 1);
      pix_addr = 17; pix_data = 1'b0;
      tick();
      chk("pix1_wren", 32'(wren), 1); chk("pix1_addr", 32'(waddr), 17); chk("pix1_data", 32'(wdata), 0);
      pix_addr = 18; pix_data = 1'b1;
      tick();
      chk("pix2_wren", 32'(wren), 1); chk("pix2_addr", 32'(waddr), 18); chk("pix2_data", 32'(wdata), 1);
      pix_valid = 1'b0;
      tick();
      chk("idle_wren", 32'(wren), 0); chk("idle_addr_hold", 32'(waddr), 18); chk("idle_data_hold", 32'(wdata), 1);
      chk("pix_drop0", 32'(drop_count), 0);

      // overlay held while pixels pulse on alternate cycles
      ovl_valid = 1'b1; ovl_addr = 800; ovl_data = 1'b1;
      for (int i = 0; i < 6; i++) begin
         pix_valid = (i % 2 == 0);
         pix_addr  = ADDR_W'(20 + i);
         pix_data  = 1'b0;
         #1 chk("alt_ovl_ready", 32'(ovl_ready), (i % 2 == 0) ? 0 : 1);
         tick();
         chk("alt_wren", 32'(wren), 1);
         chk("alt_addr", 32'(waddr), (i % 2 == 0) ? 20 + i : 800);
         chk("alt_data", 32'(wdata), (i % 2 == 0) ? 0 : 1);
      end
      pix_valid = 1'b0; ovl_addr = ADDR_W'(FB_DEPTH);
      #1 chk("ovl_oor_ready", 32'(ovl_ready), 1);
      tick();
      chk("ovl_oor_wren", 32'(wren), 0);
      ovl_valid = 1'b0;

      // out-of-range pixel
      pix_valid = 1'b1; pix_addr = ADDR_W'(FB_DEPTH); pix_data = 1'b1;
      tick();
      chk("pix_oor_wren", 32'(wren), 0);
      chk("pix_oor_drop", 32'(drop_count), 1);
      exp_drop = 1;
      pix_valid = 1'b0;
      tick();

      // full clear with pixel requests held high the whole time
      pix_valid = 1'b1; pix_addr = 5; pix_data = 1'b1; ovl_valid = 1'b1; ovl_addr = 3;
      clear_start = 1'b1;
      #1 chk("clr_ovl_ready", 32'(ovl_ready), 0);
      tick();
      clear_start = 1'b0; ovl_valid = 1'b0;
      chk("clr_start_wren", 32'(wren), 0);
      chk("clr_busy", 32'(busy), 1);
      for (int a = 0; a < FB_DEPTH; a++) begin
         tick();
         chk("sweep_write", {13'd0, wren, waddr, wdata}, {13'd0, 1'b1, ADDR_W'(a), 1'b0});
      end
      exp_drop = exp_drop + 1 + FB_DEPTH + SETTLE_CYCLES;
      for (int k = 1; k < SETTLE_CYCLES; k++) begin
         tick();
         chk("settle_wren", 32'(wren), 0);
         chk("settle_busy", 32'(busy), 1);
      end
      tick();
      chk("settle_end_wren", 32'(wren), 0);
      chk("settle_end_busy", 32'(busy), 0);
      chk("clr_drop", 32'(drop_count), 32'(sat16(exp_drop)));
      tick();
      chk("first_grant_wren", 32'(wren), 1);
      chk("first_grant_addr", 32'(waddr), 5);

      // restart at sweep address 1000, out-of-range pixels held high
      pix_addr = ADDR_W'(FB_DEPTH);
      exp_drop = exp_drop + 1;
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      ovl_valid = 1'b1;
      #1 chk("sweep_ovl_ready", 32'(ovl_ready), 0);
      ovl_valid = 1'b0;
      for (int a = 0; a < 1000; a++) begin
         tick();
         chk("pre_restart_write", {13'd0, wren, waddr, wdata}, {13'd0, 1'b1, ADDR_W'(a), 1'b0});
      end
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      chk("restart_last_addr", 32'(waddr), 1000);
      for (int a = 0; a < FB_DEPTH; a++) begin
         tick();
         chk("restart_write", {13'd0, wren, waddr, wdata}, {13'd0, 1'b1, ADDR_W'(a), 1'b0});
      end
      exp_drop = exp_drop + 1001 + FB_DEPTH + SETTLE_CYCLES;
      for (int k = 1; k < SETTLE_CYCLES; k++) begin
         tick();
         chk("restart_settle_wren", 32'(wren), 0);
      end
      tick();
      chk("restart_busy_low", 32'(busy), 0);
      chk("restart_drop_sat", 32'(drop_count), 32'(sat16(exp_drop)));
      tick();
      chk("drop_hold_sat", 32'(drop_count), 65535);
      pix_valid = 1'b0;

      // reset in the middle of a sweep
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      for (int a = 0; a < 5000; a++) tick();
      chk("mid_sweep_addr", 32'(waddr), 4999);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_wren", 32'(wren), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_drop", 32'(drop_count), 0);
      pix_valid = 1'b1; pix_addr = 7; pix_data = 1'b1;
      tick();
      pix_valid = 1'b0;
      chk("post_rst_wren", 32'(wren), 1);
      chk("post_rst_addr", 32'(waddr), 7);
      chk("post_rst_data", 32'(wdata), 1);
      tick();
      chk("post_rst_idle", 32'(wren), 0);
      chk("post_rst_busy", 32'(busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
